serializer_pipe: RTL



---
 rtl/serdes_pkg.sv | 20 ++
 rtl/serializer_pipe_stage.sv | 98 +++++++++
 rtl/serializer_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared constants and helpers for the SerDes TX serializer path.
package serdes_pkg;

    localparam int unsigned SER_IN_W_DEF  = 512;
    localparam int unsigned SER_OUT_W_DEF = 32;

    typedef enum logic {
        LSB_FIRST = 1'b0,
        MSB_FIRST = 1'b1
    } seg_order_e;

    function automatic int unsigned num_segments_f(input int unsigned in_w, input int unsigned out_w);
        return in_w / out_w;
    endfunction

    function automatic int unsigned cnt_width_f(input int unsigned in_w, input int unsigned out_w);
        return $clog2(in_w / out_w) + 1;
    endfunction

endpackage

// File: rtl/serializer_pipe_stage.sv
// Active serializer stage: holds the current word, steps through its segments
// on each sink transfer and registers data/valid/last.
module ser_shift_stage
    import serdes_pkg::*;
#(
    parameter int unsigned IN_W  = SER_IN_W_DEF,
    parameter int unsigned OUT_W = SER_OUT_W_DEF,
    parameter seg_order_e  ORDER = LSB_FIRST,
    localparam int unsigned NUM_SEG = num_segments_f(IN_W, OUT_W),
    localparam int unsigned CNT_W   = cnt_width_f(IN_W, OUT_W)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [IN_W-1:0]  load_word_i,
    input  logic [CNT_W-1:0] load_cnt_i,
    input  logic             out_ready_i,
    output logic             active_o,
    output logic             done_o,
    output logic [OUT_W-1:0] data_o,
    output logic             last_o
);

    localparam int unsigned FIRST_POS = (ORDER == MSB_FIRST) ? NUM_SEG - 1 : 0;

    logic [IN_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] nxt_idx, nxt_pos;
    logic [OUT_W-1:0] nxt_seg;
    logic             xfer;

    assign xfer    = valid_q && out_ready_i;
    assign nxt_idx = idx_q + CNT_W'(1);
    assign nxt_pos = (ORDER == MSB_FIRST) ? CNT_W'(NUM_SEG - 1) - nxt_idx : nxt_idx;

    always_comb begin
        nxt_seg = '0;
        for (int unsigned s = 0; s < NUM_SEG; s++) begin
            if (nxt_pos == CNT_W'(s)) nxt_seg = word_q[s*OUT_W +: OUT_W];
        end
    end

    // A load always wins: the top only issues it when the stage is empty or
    // its final segment is leaving on this edge.
    always_comb begin
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            word_d  = load_word_i;
            idx_d   = '0;
            cnt_d   = load_cnt_i;
            valid_d = 1'b1;
            data_d  = load_word_i[FIRST_POS*OUT_W +: OUT_W];
            last_d  = (load_cnt_i == CNT_W'(1));
        end else if (xfer) begin
            if (last_q) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
            end else begin
                idx_d  = nxt_idx;
                data_d = nxt_seg;
                last_d = ((idx_q + CNT_W'(2)) == cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign active_o = valid_q;
    assign done_o   = xfer && last_q;
    assign data_o   = data_q;
    assign last_o   = last_q;

endmodule

// File: rtl/serializer_pipe.sv
// Wide-word to segment serializer with sink backpressure, a one-word pending
// buffer for bubble-free streaming, per-word segment count and selectable order.
module serializer_pipe
    import serdes_pkg::*;
#(
    parameter int unsigned in_bit_width  = SER_IN_W_DEF,
    parameter int unsigned out_bit_width = SER_OUT_W_DEF,
    parameter bit          msb_first     = 1'b0,
    localparam int unsigned NUM_SEG = num_segments_f(in_bit_width, out_bit_width),
    localparam int unsigned CNT_W   = cnt_width_f(in_bit_width, out_bit_width)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     data_ready,
    output logic                     read_data,
    input  logic [in_bit_width-1:0]  data_in,
    input  logic [CNT_W-1:0]         seg_count,
    output logic                     write_data,
    input  logic                     out_ready,
    output logic [out_bit_width-1:0] data_out,
    output logic                     last
);

    localparam seg_order_e ORDER = msb_first ? MSB_FIRST : LSB_FIRST;

    logic                    pend_valid_q, pend_valid_d;
    logic [in_bit_width-1:0] pend_word_q, pend_word_d;
    logic [CNT_W-1:0]        pend_cnt_q, pend_cnt_d;
    logic [CNT_W-1:0]        eff_cnt;
    logic                    accept, slot_free;
    logic                    stage_load, stage_active, stage_done;
    logic [in_bit_width-1:0] load_word;
    logic [CNT_W-1:0]        load_cnt;

    assign eff_cnt = (seg_count == '0 || seg_count > CNT_W'(NUM_SEG)) ? CNT_W'(NUM_SEG) : seg_count;

    assign read_data = !reset && !pend_valid_q;
    assign accept    = read_data && data_ready;
    assign slot_free = !stage_active || stage_done;

    // accept and promotion are exclusive because accept needs pending empty.
    assign stage_load = (accept && slot_free) || (stage_done && pend_valid_q);
    assign load_word  = pend_valid_q ? pend_word_q : data_in;
    assign load_cnt   = pend_valid_q ? pend_cnt_q : eff_cnt;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_word_d  = pend_word_q;
        pend_cnt_d   = pend_cnt_q;
        if (stage_done && pend_valid_q) begin
            pend_valid_d = 1'b0;
        end else if (accept && !slot_free) begin
            pend_valid_d = 1'b1;
            pend_word_d  = data_in;
            pend_cnt_d   = eff_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_word_q  <= '0;
            pend_cnt_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_word_q  <= pend_word_d;
            pend_cnt_q   <= pend_cnt_d;
        end
    end

    ser_shift_stage #(
        .IN_W  (in_bit_width),
        .OUT_W (out_bit_width),
        .ORDER (ORDER)
    ) u_stage (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (stage_load),
        .load_word_i (load_word),
        .load_cnt_i  (load_cnt),
        .out_ready_i (out_ready),
        .active_o    (stage_active),
        .done_o      (stage_done),
        .data_o      (data_out),
        .last_o      (last)
    );

    assign write_data = stage_active;

endmodule
